// File: rtl/adc_capture_pkg.sv
// Shared constants and helpers for adc_capture: clip detection, the width of
// the sum accumulator, and offset-binary to signed audio conversion.
package adc_capture_pkg;

  localparam logic [15:0] CLIP_LO = 16'h0000;

  function automatic int sum_width(input int width, input int log_win);
    return width + log_win;
  endfunction

  function automatic logic [15:0] clip_hi(input int width);
    return 16'((17'h1 << width) - 17'h1);
  endfunction

  function automatic logic is_clip(input logic [15:0] x, input int width);
    return (x == CLIP_LO) || (x == clip_hi(width));
  endfunction

  // Flipping the MSB of an offset-binary code gives the signed value; shifting
  // left then justifies it to 16 bits with zeros below.
  function automatic logic [15:0] to_audio(input logic [15:0] x, input int width);
    logic [15:0] centered;
    centered = x ^ (16'h1 << (width - 1));
    return centered << (16 - width);
  endfunction

endpackage

// File: rtl/adc_chan_stats.sv
// Per-channel running min, max, sum and clip for one statistics window.
// The *_nxt outputs already include the sample being accepted this cycle.
module adc_chan_stats
  import adc_capture_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int LOG_WIN = 10,
  localparam int SUM_W = sum_width(WIDTH, LOG_WIN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  input  logic             wrap,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] min_nxt,
  output logic [WIDTH-1:0] max_nxt,
  output logic [SUM_W-1:0] sum_nxt,
  output logic             clip_nxt
);

  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] max_r;
  logic [SUM_W-1:0] sum_r;
  logic             clip_r;
  logic             seed_r;

  // Window values with the incoming sample folded in; first sample seeds min/max
  always_comb begin
    min_nxt  = min_r;
    max_nxt  = max_r;
    sum_nxt  = sum_r + SUM_W'(x);
    clip_nxt = clip_r | is_clip(16'(x), WIDTH);
    if (seed_r || (x < min_r)) begin
      min_nxt = x;
    end else begin
      min_nxt = min_r;
    end
    if (seed_r || (x > max_r)) begin
      max_nxt = x;
    end else begin
      max_nxt = max_r;
    end
  end

  // Running state: restart on reset, clear or publish, otherwise accumulate
  always_ff @(posedge clk) begin
    if (reset) begin
      min_r  <= '0;
      max_r  <= '0;
      sum_r  <= '0;
      clip_r <= 1'b0;
      seed_r <= 1'b1;
    end else if (clear || (accept && wrap)) begin
      sum_r  <= '0;
      clip_r <= 1'b0;
      seed_r <= 1'b1;
    end else if (accept) begin
      min_r  <= min_nxt;
      max_r  <= max_nxt;
      sum_r  <= sum_nxt;
      clip_r <= clip_nxt;
      seed_r <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_capture.sv
// Multi-channel ADC word capture with windowed statistics and audio passthrough.
// Statistics are built only when ADC_CAPTURE_STATS_EN is defined.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH = 12,
  parameter int LOG_WIN = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      din_sync,
  input  logic                      clear,
  input  logic                      passthru,
  output logic [CHANNELS*WIDTH-1:0] sample,
  output logic                      sample_valid,
  output logic [CHANNELS*WIDTH-1:0] min_val,
  output logic [CHANNELS*WIDTH-1:0] max_val,
  output logic [CHANNELS*WIDTH-1:0] avg_val,
  output logic                      stats_valid,
  output logic [CHANNELS-1:0]       clip,
  output logic [15:0]               audio_l,
  output logic [15:0]               audio_r
);

  logic             sync_d_r;
  logic             cap_s;
  logic [WIDTH-1:0] ch0_s;
  logic [WIDTH-1:0] ch1_s;

  assign cap_s = din_sync ^ sync_d_r;

  // Edge detect and capture register; reset loads sync_d so no false event follows
  always_ff @(posedge clk) begin
    sync_d_r <= din_sync;
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= cap_s;
      if (cap_s) begin
        sample <= din;
      end
    end
  end

  assign ch0_s = sample[0 +: WIDTH];
  if (CHANNELS > 1) begin : g_stereo
    assign ch1_s = sample[WIDTH +: WIDTH];
  end else begin : g_mono
    assign ch1_s = ch0_s;
  end

  // Audio path follows the captured word while passthru is high
  always_ff @(posedge clk) begin
    if (reset || !passthru) begin
      audio_l <= 16'h0000;
      audio_r <= 16'h0000;
    end else begin
      audio_l <= to_audio(16'(ch0_s), WIDTH);
      audio_r <= to_audio(16'(ch1_s), WIDTH);
    end
  end

`ifdef ADC_CAPTURE_STATS_EN
  localparam int SUM_W = sum_width(WIDTH, LOG_WIN);

  logic                        accept_s;
  logic                        wrap_s;
  logic [LOG_WIN-1:0]          cnt_r;
  logic [CHANNELS*WIDTH-1:0]   min_nxt_s;
  logic [CHANNELS*WIDTH-1:0]   max_nxt_s;
  logic [CHANNELS*WIDTH-1:0]   avg_nxt_s;
  logic [CHANNELS-1:0]         clip_nxt_s;
  logic [CHANNELS*LOG_WIN-1:0] sum_lo_unused_s;

  // A capture coinciding with clear is dropped from the window
  assign accept_s = cap_s & ~clear;
  assign wrap_s   = accept_s && (cnt_r == {LOG_WIN{1'b1}});

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic [SUM_W-1:0] sum_nxt_s;

    adc_chan_stats #(
      .WIDTH   (WIDTH),
      .LOG_WIN (LOG_WIN)
    ) u_stats (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .accept   (accept_s),
      .wrap     (wrap_s),
      .x        (din[ch*WIDTH +: WIDTH]),
      .min_nxt  (min_nxt_s[ch*WIDTH +: WIDTH]),
      .max_nxt  (max_nxt_s[ch*WIDTH +: WIDTH]),
      .sum_nxt  (sum_nxt_s),
      .clip_nxt (clip_nxt_s[ch])
    );

    assign avg_nxt_s[ch*WIDTH +: WIDTH]         = sum_nxt_s[LOG_WIN +: WIDTH];
    assign sum_lo_unused_s[ch*LOG_WIN +: LOG_WIN] = sum_nxt_s[LOG_WIN-1:0];
  end

  // Window counter wraps after 2^LOG_WIN accepted captures
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= cnt_r + LOG_WIN'(1);
    end
  end

  // Published statistics hold until the next window completes
  always_ff @(posedge clk) begin
    if (reset) begin
      min_val     <= '0;
      max_val     <= '0;
      avg_val     <= '0;
      clip        <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= wrap_s;
      if (wrap_s) begin
        min_val <= min_nxt_s;
        max_val <= max_nxt_s;
        avg_val <= avg_nxt_s;
        clip    <= clip_nxt_s;
      end
    end
  end
`else
  logic stats_unused_s;

  assign stats_unused_s = clear;
  assign min_val        = '0;
  assign max_val        = '0;
  assign avg_val        = '0;
  assign clip           = '0;
  assign stats_valid    = 1'b0;
`endif

endmodule
